// File: rtl/alu_ctrl_unit.sv
// ALU control: decodes issued ops into the ALU select, stretches MUL as a
// multicycle path, evaluates the condition code and commits the flags.
module alu_ctrl_unit #(
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [2:0] in_cond,
  input  logic       in_setf,
  output logic [2:0] alu_control,
  input  logic [3:0] alu_flags,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_wr_rd,
  output logic       out_illegal,
  output logic       cond_pass,
  output logic [3:0] flags_q
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] cond;
    logic       setf;
    logic       ill;
  } stage_t;

  state_t        st;
  stage_t        stg;
  logic [CW-1:0] cnt;

  logic accept;
  logic hs;
  logic in_mul;
  logic fn, fz, fv;

  assign out_valid = (st == VALID);
  assign in_ready  = ((st == IDLE) | (out_valid & out_ready)) & ~flush;
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign in_mul    = (in_op == OP_MUL);

  assign fn = flags_q[3];
  assign fz = flags_q[2];
  assign fv = flags_q[0];

  always_comb begin
    cond_pass = 1'b1;
    unique case (stg.cond)
      3'd0: cond_pass = 1'b1;
      3'd1: cond_pass = fz;
      3'd2: cond_pass = ~fz;
      3'd3: cond_pass = ~fz & (fn == fv);
      3'd4: cond_pass = (fn == fv);
      3'd5: cond_pass = (fn != fv);
      3'd6: cond_pass = fz | (fn != fv);
      3'd7: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = 3'b100;
    unique case (stg.op)
      OP_ADD: alu_control = 3'b000;
      OP_SUB: alu_control = 3'b001;
      OP_CMP: alu_control = 3'b001;
      OP_MUL: alu_control = 3'b010;
      OP_SLL: alu_control = 3'b011;
      OP_SRL: alu_control = 3'b111;
      default: alu_control = 3'b100;
    endcase
  end

  assign out_illegal = out_valid & stg.ill;
  assign out_wr_rd   = out_valid & cond_pass &
                       (stg.op != OP_CMP) & ~stg.ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      stg     <= '0;
      flags_q <= '0;
    end else if (flush) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      if (hs & stg.setf & cond_pass & ~stg.ill)
        flags_q <= alu_flags;
      if (accept) begin
        stg.op   <= in_op;
        stg.cond <= in_cond;
        stg.setf <= in_setf | (in_op == OP_CMP);
        stg.ill  <= (in_op > OP_CMP);
        if (in_mul && (MUL_CYCLES > 1)) begin
          st  <= WAIT;
          cnt <= CW'(1);
        end else begin
          st  <= VALID;
          cnt <= '0;
        end
      end else begin
        unique case (st)
          WAIT: begin
            if (cnt == CW'(MUL_CYCLES - 1)) begin
              st  <= VALID;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          VALID: if (out_ready) st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with MUL_CYCLES=3.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_alu_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_cond;
  logic       in_setf;
  logic [2:0] alu_control;
  logic [3:0] alu_flags;
  logic       out_valid;
  logic       out_ready;
  logic       out_wr_rd;
  logic       out_illegal;
  logic       cond_pass;
  logic [3:0] flags_q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_ctrl_unit #(.MUL_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_cond(in_cond),
    .in_setf(in_setf),
    .alu_control(alu_control),
    .alu_flags(alu_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_wr_rd(out_wr_rd),
    .out_illegal(out_illegal),
    .cond_pass(cond_pass),
    .flags_q(flags_q)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic edge_in;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [2:0] c,
                        input logic s);
    in_valid = 1'b1;
    in_op    = op;
    in_cond  = c;
    in_setf  = s;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'd0;
    in_cond   = 3'd0;
    in_setf   = 1'b0;
    alu_flags = 4'b0000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_ctl", 8'(alu_control), 8'd0);
    chk("rst_flags", 8'(flags_q), 8'd0);
    chk("rst_ready", 8'(in_ready), 8'd1);
    chk("rst_cpass", 8'(cond_pass), 8'd1);
    chk("rst_wr", 8'(out_wr_rd), 8'd0);
    chk("rst_ill", 8'(out_illegal), 8'd0);

    // ADD setf, ALU returns Z
    set_op(4'd0, 3'd0, 1'b1);
    alu_flags = 4'b0100;
    edge_in;
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", 8'(out_valid), 8'd1);
    chk("add_ctl", 8'(alu_control), 8'b000);
    chk("add_wr", 8'(out_wr_rd), 8'd1);
    edge_in;
    @(negedge clk);
    chk("add_flags", 8'(flags_q), 8'b0100);
    chk("add_idle", 8'(out_valid), 8'd0);

    // ADD setf to get N=1,V=0
    set_op(4'd0, 3'd0, 1'b1);
    alu_flags = 4'b1000;
    edge_in;
    in_valid = 1'b0;
    edge_in;
    @(negedge clk);
    chk("n_flags", 8'(flags_q), 8'b1000);

    // SUB GT setf: fails, flags unchanged
    set_op(4'd1, 3'd3, 1'b1);
    alu_flags = 4'b0110;
    edge_in;
    in_valid = 1'b0;
    @(negedge clk);
    chk("gt_cpass", 8'(cond_pass), 8'd0);
    chk("gt_wr", 8'(out_wr_rd), 8'd0);
    edge_in;
    @(negedge clk);
    chk("gt_flags", 8'(flags_q), 8'b1000);

    // CMP then SUB EQ back to back
    set_op(4'd5, 3'd0, 1'b0);
    alu_flags = 4'b0100;
    edge_in;
    set_op(4'd1, 3'd1, 1'b0);
    @(negedge clk);
    chk("cmp_valid", 8'(out_valid), 8'd1);
    chk("cmp_ctl", 8'(alu_control), 8'b001);
    chk("cmp_wr", 8'(out_wr_rd), 8'd0);
    chk("cmp_ready", 8'(in_ready), 8'd1);
    edge_in;
    in_valid  = 1'b0;
    alu_flags = 4'b0010;
    @(negedge clk);
    chk("b2b_valid", 8'(out_valid), 8'd1);
    chk("cmp_flags", 8'(flags_q), 8'b0100);
    chk("eq_cpass", 8'(cond_pass), 8'd1);
    chk("eq_wr", 8'(out_wr_rd), 8'd1);
    edge_in;
    @(negedge clk);
    chk("eq_noflag", 8'(flags_q), 8'b0100);
    chk("eq_done", 8'(out_valid), 8'd0);

    // MUL, three cycles
    set_op(4'd2, 3'd0, 1'b0);
    alu_flags = 4'b1111;
    edge_in;
    in_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk($sformatf("mul_ready%0d", i), 8'(in_ready), 8'd0);
      chk($sformatf("mul_ctl%0d", i), 8'(alu_control), 8'b010);
      chk($sformatf("mul_nv%0d", i), 8'(out_valid), 8'd0);
      edge_in;
    end
    @(negedge clk);
    chk("mul_valid", 8'(out_valid), 8'd1);
    chk("mul_ctl3", 8'(alu_control), 8'b010);
    chk("mul_wr", 8'(out_wr_rd), 8'd1);
    edge_in;
    @(negedge clk);
    chk("mul_flags", 8'(flags_q), 8'b0100);

    // illegal op with stall
    set_op(4'd9, 3'd0, 1'b1);
    out_ready = 1'b0;
    edge_in;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ill_ctl%0d", i), 8'(alu_control), 8'b100);
      chk($sformatf("ill_flag%0d", i), 8'(out_illegal), 8'd1);
      chk($sformatf("ill_wr%0d", i), 8'(out_wr_rd), 8'd0);
      chk($sformatf("ill_valid%0d", i), 8'(out_valid), 8'd1);
      chk($sformatf("ill_ready%0d", i), 8'(in_ready), 8'd0);
      edge_in;
    end
    out_ready = 1'b1;
    edge_in;
    @(negedge clk);
    chk("ill_done", 8'(out_valid), 8'd0);
    chk("ill_flags", 8'(flags_q), 8'b0100);

    // flush during MUL WAIT with in_valid high
    set_op(4'd2, 3'd0, 1'b1);
    edge_in;
    set_op(4'd0, 3'd0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", 8'(in_ready), 8'd0);
    edge_in;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_idle", 8'(out_valid), 8'd0);
    chk("fl_ready2", 8'(in_ready), 8'd1);
    chk("fl_flags", 8'(flags_q), 8'b0100);
    edge_in;
    @(negedge clk);
    chk("fl_noacc", 8'(out_valid), 8'd0);

    // flush in IDLE blocks an accept
    set_op(4'd0, 3'd0, 1'b1);
    flush = 1'b1;
    #1;
    chk("fli_ready", 8'(in_ready), 8'd0);
    edge_in;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fli_noacc", 8'(out_valid), 8'd0);

    // reset while VALID clears flags
    set_op(4'd0, 3'd0, 1'b1);
    out_ready = 1'b0;
    edge_in;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rv_valid", 8'(out_valid), 8'd1);
    rst = 1'b1;
    edge_in;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rv_flags", 8'(flags_q), 8'd0);
    chk("rv_idle", 8'(out_valid), 8'd0);
    chk("rv_ready", 8'(in_ready), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_unit.md
# alu_ctrl_unit

Control-side partner of the scalar ALU in the execute stage. It decodes issued operations into the 3-bit `alu_control` select that drives the ALU. It holds the operation for a configurable number of cycles on multiplies, so the multiplier runs as a multicycle path. It then takes the ALU's `{N,Z,C,V}` flags back, evaluates the instruction's condition code, and commits the flags to an architectural flag register.

## Interface
Parameters:
- `MUL_CYCLES`, 2: cycles the MUL select is held before the result is valid; must be ≥1. A value of 1 means single-cycle.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `flush`  in  1  synchronous kill of the in-flight operation; the flag register is kept.
- `in_valid`  in  1  issue request.
- `in_ready`  out  1  the unit can accept an operation this cycle.
- `in_op`  in  4  operation code: 0 ADD, 1 SUB, 2 MUL, 3 SLL, 4 SRL, 5 CMP; 6–15 are illegal.
- `in_cond`  in  3  condition: 0 AL, 1 EQ, 2 NE, 3 GT, 4 GE, 5 LT, 6 LE, 7 NV.
- `in_setf`  in  1  the instruction writes flags; CMP forces this to 1.
- `alu_control`  out  3  select to the ALU: ADD 000, SUB/CMP 001, MUL 010, SLL 011, SRL 111, illegal 100.
- `alu_flags`  in  4  `{N,Z,C,V}` returned combinationally by the ALU for the current `alu_control`.
- `out_valid`  out  1  result and decision are valid.
- `out_ready`  in  1  the downstream stage accepts the result.
- `out_wr_rd`  out  1  write the destination register: `cond_pass` and not CMP and not illegal.
- `out_illegal`  out  1  the held operation is illegal.
- `cond_pass`  out  1  the condition is true against `flags_q`.
- `flags_q`  out  4  architectural `{N,Z,C,V}` register.

## Operation
- One-entry stage register holds op, cond, setf and illegal. `alu_control` is decoded from the stage register only, never from `in_op`.
- FSM states:
  - IDLE: stage empty.
  - WAIT: a MUL is held while counting.
  - VALID: `out_valid`=1.
- FSM transitions:
  - Accept (`in_valid & in_ready`) with a non-MUL op, or `MUL_CYCLES`=1: go to VALID.
  - Accept with MUL and `MUL_CYCLES`>1: go to WAIT with the counter at 1.
  - WAIT: increment the counter each cycle; when it reaches `MUL_CYCLES`-1, go to VALID on the next edge.
  - VALID with handshake: if a new accept occurs in the same cycle, reload and apply the rules above; otherwise go to IDLE.
  - VALID without `out_ready`: hold all outputs stable.
- `in_ready` = (IDLE | (VALID & `out_ready`)) & ~`flush`. It is 0 throughout WAIT.
- Condition evaluation uses `flags_q`:
  - EQ = Z; NE = ~Z.
  - GT = ~Z & (N==V); GE = N==V.
  - LT = N≠V; LE = Z | (N≠V).
  - AL = 1; NV = 0.
- Flag commit: on the output handshake, if setf & `cond_pass` & ~illegal, then `flags_q` <= `alu_flags`. Otherwise `flags_q` is unchanged.
- Illegal op: drives `alu_control`=100, `out_illegal`=1, `out_wr_rd`=0, and never writes flags. It still completes through VALID.
- `flush`: any state goes to IDLE next edge, with no flag commit and no accept. `flush` takes priority over a handshake in the same cycle.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `flags_q`=0000, `alu_control`=000.
  - `out_valid`=0, `out_wr_rd`=0, `out_illegal`=0.
  - `cond_pass` is decoded from the cleared stage: cond AL, so 1. It is qualified by `out_valid`=0.
  - `in_ready`=1 after the reset edge.
- `rst` mid-operation: the held operation is discarded and flags are cleared; it behaves exactly as a reset from idle.
- Latency for non-MUL ops: accepted at edge k, `out_valid`=1 from cycle k+1.
- Latency for MUL: `out_valid`=1 from cycle k+`MUL_CYCLES`. `alu_control`=010 is stable from k+1 until the handshake.
- Back-to-back throughput is one op per cycle with `out_ready` held at 1. A flag commit at edge j is visible to the condition of the op that is VALID in cycle j+1.

## Test plan
- Reset, then ADD with setf, ALU returns 0100, handshake -> `out_valid` at k+1, `alu_control`=000, `flags_q`=0100.
- CMP then EQ-conditioned SUB back to back with `out_ready`=1 -> CMP commits Z=1; SUB has `cond_pass`=1, `out_wr_rd`=1, and no flag write (setf=0); one op per cycle.
- MUL with `MUL_CYCLES`=3 -> `in_ready`=0 for 2 cycles, `alu_control`=010 stable, `out_valid` at k+3.
- GT with `flags_q`=1000 (N=1, V=0), setf=1 -> `cond_pass`=0, `out_wr_rd`=0, `flags_q` unchanged.
- Op 9 -> `alu_control`=100, `out_illegal`=1, no flag write; `out_ready`=0 for 4 cycles -> all outputs held.
- `flush` during MUL WAIT with `in_valid`=1 -> IDLE next cycle, op not accepted, `flags_q` kept; `rst` in VALID -> `flags_q`=0000.
